// File: rtl/prover_adder_tree_arb_if.sv
// Requester-side bus of the shared adder-tree arbiter.
// Requesters (master) raise req with a vector on req_data. The arbiter (slave)
// answers with a grant pulse and later a done pulse carrying the sum on result.
interface prover_adder_tree_arb_if #(
    parameter int nreq   = 4,
    parameter int ngates = 8,
    parameter int fnbits = 32
);
    logic [nreq-1:0]                         req;
    logic [nreq-1:0][ngates-1:0][fnbits-1:0] req_data;
    logic [nreq-1:0]                         grant;
    logic [nreq-1:0]                         done;
    logic [fnbits-1:0]                       result;

    modport master (
        output req,
        output req_data,
        input  grant,
        input  done,
        input  result
    );

    modport slave (
        input  req,
        input  req_data,
        output grant,
        output done,
        output result
    );
endinterface

// File: rtl/prover_adder_tree_arb.sv
// Round-robin arbiter sharing one pipelined adder tree among nreq requesters.
// The winning vector is latched and fired into the tree with the winner index as its tag.
// Tagged tree results come back as a one-cycle done pulse to the owning requester.
// The arbiter does no arithmetic; all sums are formed inside the tree.
module prover_adder_tree_arb #(
    parameter int nreq   = 4,
    parameter int ngates = 8,
    parameter int ntagb  = $clog2(nreq),
    parameter int maxout = 8,
    parameter int fnbits = 32
) (
    input  logic                          clk,
    input  logic                          rstb,
    prover_adder_tree_arb_if.slave        bus,
    output logic                          idle,
    output logic                          tree_en,
    output logic [ngates-1:0][fnbits-1:0] tree_in,
    output logic [ntagb-1:0]              tree_in_tag,
    input  logic                          tree_in_ready,
    input  logic                          tree_idle,
    input  logic                          tree_out_pulse,
    input  logic [fnbits-1:0]             tree_out,
    input  logic [ntagb-1:0]              tree_out_tag
);
    localparam int              cntw    = $clog2(maxout + 1);
    localparam logic [cntw-1:0] max_cnt = cntw'(maxout);

    typedef enum logic [1:0] {
        st_idle,
        st_fire,
        st_hold,
        st_waitrdy
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ntagb-1:0] rr_ptr;
    logic [ntagb-1:0] winner;
    logic [ntagb-1:0] ptr_after_winner;
    logic [nreq-1:0]  win_onehot;
    logic [nreq-1:0]  done_vec;
    logic             found;
    logic             arb_go;
    logic [cntw-1:0]  inflight;

    // Find the first active request at or above the rr pointer, wrapping around.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < nreq; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if (!found && bus.req[ntagb'(idx)]) begin
                found  = 1'b1;
                winner = ntagb'(idx);
            end
        end
    end

    // Decode the winner and the returning tag into one-hot vectors; pointer moves past the winner.
    always_comb begin
        win_onehot = '0;
        done_vec   = '0;
        for (int k = 0; k < nreq; k++) begin
            win_onehot[k] = (winner == ntagb'(k));
            done_vec[k]   = (tree_out_tag == ntagb'(k));
        end
        ptr_after_winner = (winner == ntagb'(nreq - 1)) ? '0 : winner + 1'b1;
    end

    // Next-state logic: arbitrate in IDLE, fire once, then wait for the tree to accept again.
    always_comb begin
        state_nxt = state;
        arb_go    = 1'b0;
        case (state)
            st_idle: begin
                if (found && tree_in_ready && (inflight < max_cnt)) begin
                    arb_go    = 1'b1;
                    state_nxt = st_fire;
                end
            end
            st_fire:    state_nxt = st_hold;
            st_hold:    state_nxt = st_waitrdy;
            st_waitrdy: begin
                if (tree_in_ready) begin
                    state_nxt = st_idle;
                end
            end
            default:    state_nxt = st_idle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
        if (!rstb) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue path: latch the winning vector and tag, pulse grant and tree_en during FIRE.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bus.grant   <= '0;
            tree_en     <= 1'b0;
            tree_in     <= '0;
            tree_in_tag <= '0;
            rr_ptr      <= '0;
        end else begin
            bus.grant <= '0;
            tree_en   <= arb_go;
            if (arb_go) begin
                bus.grant   <= win_onehot;
                tree_in     <= bus.req_data[winner];
                tree_in_tag <= winner;
                rr_ptr      <= ptr_after_winner;
            end
        end
    end

    // Return path: register each tree result and pulse done to the tagged owner.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bus.done   <= '0;
            bus.result <= '0;
        end else begin
            bus.done <= '0;
            if (tree_out_pulse) begin
                bus.result <= tree_out;
                bus.done   <= done_vec;
            end
        end
    end

    // In-flight count: up on fire, down on a returned sum, unchanged when both coincide.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            inflight <= '0;
        end else begin
            case ({tree_en, tree_out_pulse})
                2'b10: inflight <= inflight + 1'b1;
                2'b01: begin
                    if (inflight != '0) begin
                        inflight <= inflight - 1'b1;
                    end
                end
                default: inflight <= inflight;
            endcase
        end
    end

    assign idle = (state == st_idle) && (inflight == '0) && tree_idle && !(|bus.done);

    // A returned tag that names no requester indicates a broken tree or tag width mismatch.
    tag_in_range: assert property (@(posedge clk) disable iff (!rstb)
        tree_out_pulse |-> (|done_vec));

endmodule
